char_line_arbiter: RTL and testbench

Shares one ASCII character stream sink (UART TX CharFifo) between N line producers, such as itoa2 instances, each emitting "num0\tnum1\n" lines. Grants are round-robin and line-atomic: once a producer is granted, it keeps the sink until its terminator character has been accepted, so lines never interleave. The output character is registered (one-entry stage) with a valid/ready handshake toward the FIFO.

---
 rtl/char_arb_pkg.sv | 16 +
 rtl/char_line_arbiter_rr_pick.sv | 30 +++
 rtl/char_line_arbiter.sv | 151 +++++++++++++++
 tb/tb_char_line_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_arb_pkg.sv
// Shared types and constants for the line-atomic character arbiter.
// Optional stall timeout is enabled by CHAR_LINE_ARB_TIMEOUT_EN.
package char_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LOCKED,
    FLUSH
  } arb_state_e;

  localparam logic [7:0] ASCII_LF  = 8'h0A;
  localparam logic [7:0] ASCII_TAB = 8'h09;

  localparam int TIMEOUT_DEFAULT = 1024;

endpackage

// File: rtl/char_line_arbiter_rr_pick.sv
// Combinational round-robin search: first valid index after ptr,
// wrapping modulo N.
module rr_pick #(
  parameter int N  = 2,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  valid,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    int cand;
    win  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(ptr) + k) % N;
      if (!any && valid[cand]) begin
        any       = 1'b1;
        win[cand] = 1'b1;
        idx       = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/char_line_arbiter.sv
// Round-robin, line-atomic share of one character sink among N_REQ
// producers. Define CHAR_LINE_ARB_TIMEOUT_EN for stalled-owner flush.
module char_line_arbiter
  import char_arb_pkg::*;
#(
  parameter int          N_REQ     = 2,
  parameter logic [7:0]  TERM_CHAR = ASCII_LF,
  parameter int          TIMEOUT   = TIMEOUT_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [8*N_REQ-1:0] req_do,
  input  logic [N_REQ-1:0]   req_doValid,
  output logic [N_REQ-1:0]   req_doReady,
  output logic [7:0]         do_data,
  output logic               doValid,
  input  logic               doReady,
  output logic [N_REQ-1:0]   grant,
  output logic               busy
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  if (N_REQ < 1 || N_REQ > 8 || TIMEOUT < 2) begin : g_bad_cfg
    $error("char_line_arbiter: bad parameters");
  end

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IW-1:0]    rr_ptr_q, rr_ptr_d;
  logic [7:0]       do_q, do_d;
  logic             do_valid_q, do_valid_d;

  logic [N_REQ-1:0] pick_win;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic [7:0] own_char;
  logic       own_valid;
  logic       own_xfer;
  logic       out_free;

  rr_pick #(.N(N_REQ), .IW(IW)) u_pick (
    .valid (req_doValid),
    .ptr   (rr_ptr_q),
    .win   (pick_win),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // While locked, rr_ptr_q holds the owner index.
  assign own_char  = req_do[8*int'(rr_ptr_q) +: 8];
  assign own_valid = req_doValid[rr_ptr_q];
  assign out_free  = !do_valid_q || doReady;

`ifdef CHAR_LINE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT) + 1;
  logic [CW-1:0] stall_q, stall_d;

  always_comb begin
    stall_d = '0;
    if (state_q == LOCKED && !own_xfer) begin
      stall_d = own_valid ? stall_q : stall_q + 1'b1;
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    rr_ptr_d    = rr_ptr_q;
    do_d        = do_q;
    do_valid_d  = do_valid_q;
    req_doReady = '0;
    own_xfer    = 1'b0;

    if (do_valid_q && doReady) begin
      do_valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          grant_d  = pick_win;
          rr_ptr_d = pick_idx;
          state_d  = LOCKED;
        end
      end
      LOCKED: begin
        req_doReady = grant_q & {N_REQ{out_free}};
        own_xfer    = own_valid && out_free;
        if (own_xfer) begin
          do_d       = own_char;
          do_valid_d = 1'b1;
          if (own_char == TERM_CHAR) begin
            grant_d = '0;
            state_d = IDLE;
          end
        end
`ifdef CHAR_LINE_ARB_TIMEOUT_EN
        else if (!own_valid && stall_q == CW'(TIMEOUT - 1)) begin
          state_d = FLUSH;
        end
`endif
      end
`ifdef CHAR_LINE_ARB_TIMEOUT_EN
      FLUSH: begin
        // Terminate the truncated line so the sink sees a whole line.
        if (out_free) begin
          do_d       = TERM_CHAR;
          do_valid_d = 1'b1;
          grant_d    = '0;
          state_d    = IDLE;
        end
      end
`endif
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= IDLE;
      grant_q    <= '0;
      rr_ptr_q   <= IW'(N_REQ - 1);
      do_q       <= '0;
      do_valid_q <= 1'b0;
`ifdef CHAR_LINE_ARB_TIMEOUT_EN
      stall_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      rr_ptr_q   <= rr_ptr_d;
      do_q       <= do_d;
      do_valid_q <= do_valid_d;
`ifdef CHAR_LINE_ARB_TIMEOUT_EN
      stall_q    <= stall_d;
`endif
    end
  end

  assign do_data = do_q;
  assign doValid = do_valid_q;
  assign grant   = grant_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_char_line_arbiter.sv
// Randomized bench for char_line_arbiter; per-requester char queues
// feed an in-flight scoreboard plus directed line-order checks.
module tb_char_line_arbiter;
  import char_arb_pkg::*;

  localparam int N = 2;
`ifdef CHAR_LINE_ARB_TIMEOUT_EN
  localparam int TMO = 16;
`else
  localparam int TMO = 1024;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic [8*N-1:0] req_do;
  logic [N-1:0]   req_doValid;
  logic [N-1:0]   req_doReady;
  logic [7:0]     do_data;
  logic           doValid;
  logic           doReady;
  logic [N-1:0]   grant;
  logic           busy;

  always #5 clk = ~clk;

  char_line_arbiter #(
    .N_REQ     (N),
    .TERM_CHAR (8'h0A),
    .TIMEOUT   (TMO)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_do      (req_do),
    .req_doValid (req_doValid),
    .req_doReady (req_doReady),
    .do_data     (do_data),
    .doValid     (doValid),
    .doReady     (doReady),
    .grant       (grant),
    .busy        (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] pend [N][$];
  logic [7:0] infl [$];
  logic [7:0] out_log [$];

  int         vpct, rpct, rdy_low, exp_owner;
  int         cyc, first_vcyc, cur_src, total;
  bit         chk_src, line_open, prev_stall;
  logic [7:0] prev_do;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic bit pend_empty();
    for (int i = 0; i < N; i++)
      if (pend[i].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic add_line(input int r, input string s);
    for (int k = 0; k < s.len(); k++) pend[r].push_back(s[k]);
  endtask

  task automatic expect_log(input string tag, input string s);
    chk({tag, "_len"}, out_log.size(), s.len());
    for (int k = 0; k < s.len() && k < out_log.size(); k++)
      chk(tag, out_log[k], s[k]);
    out_log.delete();
  endtask

  task automatic step();
    logic [7:0] c;
    @(negedge clk);
    if (prev_stall) begin
      chk("hold_valid", doValid, 1);
      chk("hold_data", do_data, prev_do);
    end
    for (int i = 0; i < N; i++) begin
      if (pend[i].size() != 0 && $urandom_range(99) < vpct) begin
        req_doValid[i]    = 1'b1;
        req_do[8*i +: 8]  = pend[i][0];
      end else begin
        req_doValid[i]    = 1'b0;
        req_do[8*i +: 8]  = 8'($urandom);
      end
    end
    if (rdy_low > 0) begin
      doReady = 1'b0;
      rdy_low--;
    end else begin
      doReady = ($urandom_range(99) < rpct);
    end
    #1;
    chk("grant_onehot0", $onehot0(grant), 1);
    chk("rdy_outside_grant", req_doReady & ~grant, 0);
    if (doValid && !doReady) chk("bp_rdy", req_doReady, 0);
    if (exp_owner >= 0) begin
      chk("stall_grant", grant, 1 << exp_owner);
      for (int i = 0; i < N; i++)
        if (i != exp_owner) chk("stall_other_rdy", req_doReady[i], 0);
    end
    if (doValid && first_vcyc < 0) first_vcyc = cyc;
    if (doValid && doReady) begin
      out_log.push_back(do_data);
      if (chk_src) begin
        if (infl.size() == 0) chk("out_unexpected", 1, 0);
        else chk("out_char", do_data, infl.pop_front());
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_doValid[i] && req_doReady[i]) begin
        c = pend[i].pop_front();
        infl.push_back(c);
        if (chk_src && line_open) chk("atomic_src", i, cur_src);
        cur_src   = i;
        line_open = (c != ASCII_LF);
      end
    end
    prev_stall = doValid && !doReady;
    prev_do    = do_data;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!(pend_empty() && !busy && !doValid) && n < budget) begin
      step();
      n++;
    end
    chk("drain_in_budget", n < budget, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst         = 1'b0;
    req_doValid = '0;
    doReady     = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_doValid", doValid, 0);
    chk("rst_grant", grant, 0);
    chk("rst_do", do_data, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b1;
    for (int i = 0; i < N; i++) pend[i].delete();
    infl.delete();
    out_log.delete();
    prev_stall = 0;
    line_open  = 0;
    cyc        = 0;
    first_vcyc = -1;
    exp_owner  = -1;
    rdy_low    = 0;
    vpct       = 100;
    rpct       = 100;
    chk_src    = 1;
  endtask

  initial begin
    rst         = 1'b0;
    req_do      = '0;
    req_doValid = '0;
    doReady     = 1'b1;

    // single line, latency
    do_reset();
    add_line(0, "12\t34\n");
    drain(100);
    chk("t1_first_latency", first_vcyc, 2);
    chk("t1_grant_end", grant, 0);
    expect_log("t1_line", "12\t34\n");

    // contention and alternation
    do_reset();
    add_line(0, "5\t6\n");
    add_line(1, "8\t9\n");
    drain(100);
    expect_log("t2_round1", "5\t6\n8\t9\n");
    add_line(0, "11\t22\n");
    add_line(1, "33\t44\n");
    drain(100);
    expect_log("t2_round2", "11\t22\n33\t44\n");

    // back-pressure mid-line
    do_reset();
    add_line(0, "123\t45\n");
    run(4);
    rdy_low = 5;
    drain(100);
    expect_log("t3_line", "123\t45\n");

    // owner stall holds the lock
    do_reset();
    add_line(0, "7\t");
    add_line(1, "1\t2\n");
    run(4);
    exp_owner = 0;
    run(8);
    exp_owner = -1;
    add_line(0, "8\n");
    drain(100);
    expect_log("t4_order", "7\t8\n1\t2\n");

`ifdef CHAR_LINE_ARB_TIMEOUT_EN
    // stalled owner is flushed with a terminator
    do_reset();
    chk_src = 0;
    add_line(0, "7\t");
    add_line(1, "1\t2\n");
    drain(300);
    expect_log("t5_flush", "7\t\n1\t2\n");
`endif

    // reset mid-line
    do_reset();
    add_line(0, "1234\n");
    run(3);
    chk("t6_pre_valid", doValid, 1);
    chk("t6_pre_grant", grant, 2'b01);
    do_reset();
    add_line(1, "9\n");
    add_line(0, "3\n");
    drain(100);
    expect_log("t6_after", "3\n9\n");

    // randomized traffic
    for (int round = 0; round < 3; round++) begin
      do_reset();
      vpct  = 50 + $urandom_range(40);
      rpct  = 40 + $urandom_range(50);
      total = 0;
      for (int r = 0; r < N; r++) begin
        for (int l = 0; l < 4; l++) begin
          string s;
          s = $sformatf("%0d\t%0d\n", $urandom_range(999),
                        $urandom_range(99999));
          total += s.len();
          add_line(r, s);
        end
      end
      drain(5000);
      chk("rand_count", out_log.size(), total);
      chk("rand_infl_empty", infl.size(), 0);
      chk("rand_grant_end", grant, 0);
      out_log.delete();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
